systolic_seq_ctrl: RTL
======================

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, operand width; it SHALL match the 4x4 systolic_array operand ports.
REQ-002 Parameter DRAIN, default 4, number of flush cycles after the last operand is fed; legal range 1..15.
REQ-003 The block SHALL have the following ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one 4x4 multiply.
- a_we  in  1  A-buffer write strobe.
- a_addr  in  4  {row[1:0], col[1:0]} of matrix A.
- a_data  in  DATA_W  A element.
- b_we  in  1  B-buffer write strobe.
- b_addr  in  4  {row[1:0], col[1:0]} of matrix B.
- b_data  in  DATA_W  B element.
- inp_west0, inp_west4, inp_west8, inp_west12  out  DATA_W each  row 0..3 operands to the array.
- inp_north0..inp_north3  out  DATA_W each  column 0..3 operands to the array.
- array_clr  out  1  accumulator clear to the array.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- wr_err  out  1  sticky write-while-busy flag (see Configuration).

Function
REQ-004 The block SHALL hold two 16-entry DATA_W operand buffers, A[i][k] and B[k][j].
REQ-005 A write with a_we or b_we high SHALL be accepted only in IDLE, at address i*4+k or k*4+j respectively.
REQ-006 A and B writes in the same cycle SHALL both take effect.
REQ-007 Writes outside IDLE SHALL be dropped and SHALL leave the buffers unchanged.
REQ-008 The FSM states SHALL be IDLE, CLEAR, FEED, DRAIN and DONE.
REQ-009 IDLE SHALL go to CLEAR when start is high, and SHALL otherwise stay in IDLE.
REQ-010 start SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-011 CLEAR SHALL last exactly 1 cycle with array_clr=1, then go to FEED; array_clr SHALL be 0 in all other states.
REQ-012 FEED SHALL last exactly 7 cycles, indexed t=0..6 by a 3-bit counter, then go to DRAIN.
REQ-013 In FEED cycle t, the row i west output SHALL equal A[i][t-i] when 0<=t-i<=3, and 0 otherwise.
REQ-014 In FEED cycle t, inp_north_j SHALL equal B[t-j][j] when 0<=t-j<=3, and 0 otherwise.
REQ-015 All eight operand outputs SHALL be driven from registers and SHALL be 0 in IDLE, CLEAR, DRAIN and DONE.
REQ-016 DRAIN SHALL last exactly DRAIN cycles, then go to DONE.
REQ-017 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-018 The done pulse SHALL occur exactly 9+DRAIN cycles after the cycle in which start was sampled in IDLE (13 cycles at the default).
REQ-019 No arithmetic is performed in this block; the counters SHALL wrap only under FSM control and SHALL never free-run.

Reset
REQ-020 rst SHALL take priority over every other input.
REQ-021 On the clock edge with rst=1: state=IDLE, all counters=0, all 32 buffer entries=0, all operand outputs=0, array_clr=0, busy=0, done=0, wr_err=0.
REQ-022 An rst asserted mid-operation SHALL abort the operation with no done pulse; a start sampled on the same edge as rst SHALL be ignored.

Configuration
REQ-023 The feature SHALL be controlled by macro SYSTOLIC_SEQ_CTRL_WRERR_EN.
REQ-024 With the macro defined, wr_err SHALL set on any a_we or b_we while busy=1, and SHALL clear only by rst.
REQ-025 With the macro undefined, wr_err SHALL be tied to 0 and no flag register SHALL exist.
REQ-026 Write dropping per REQ-007 SHALL apply in both configurations.

Verification
REQ-027 Load A=identity, B[k][j]=4k+j+1, pulse start -> FEED t=0: inp_west0=1, inp_north0=1, others 0; t=3: inp_west12=0, inp_north3=B[0][3]=4; done 13 cycles after start; array out00..out15 = B.
REQ-028 A all 1, B all 2 -> inp_west0 is nonzero only in FEED t=0..3; inp_west12 only in t=3..6; every array output = 0x0008 when done=1.
REQ-029 Pulse start again during FEED and in the DONE cycle -> no extra CLEAR, exactly one done pulse.
REQ-030 Assert rst at FEED t=2 -> next cycle all outputs 0, busy=0; no done; buffers read back 0 on a following run.
REQ-031 Macro defined, a_we=1 with a_data=0xFF at addr 0 during DRAIN -> wr_err=1 and stays 1; next run feeds the old A[0][0]. Macro undefined, same stimulus -> wr_err stays 0 and A unchanged.
REQ-032 Simultaneous a_we and b_we in IDLE at addr 5 with data 0x11 and 0x22 -> FEED t=2: inp_west4=0x11, inp_north1=0x22.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a 4x4 systolic array: buffers A and B, then streams skewed operands.
// Optional sticky write-while-busy flag enabled by defining SYSTOLIC_SEQ_CTRL_WRERR_EN.
module systolic_seq_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DRAIN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              a_we,
    input  logic [3:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_we,
    input  logic [3:0]        b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] inp_west0,
    output logic [DATA_W-1:0] inp_west4,
    output logic [DATA_W-1:0] inp_west8,
    output logic [DATA_W-1:0] inp_west12,
    output logic [DATA_W-1:0] inp_north0,
    output logic [DATA_W-1:0] inp_north1,
    output logic [DATA_W-1:0] inp_north2,
    output logic [DATA_W-1:0] inp_north3,
    output logic              array_clr,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);

    typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_t;

    state_t            state;
    logic [2:0]        feed_cnt;
    logic [3:0]        drain_cnt;
    logic [DATA_W-1:0] a_mem   [16];
    logic [DATA_W-1:0] b_mem   [16];
    logic [DATA_W-1:0] west_q  [4];
    logic [DATA_W-1:0] north_q [4];
    logic [DATA_W-1:0] west_d  [4];
    logic [DATA_W-1:0] north_d [4];
    logic              load_ops;
    logic [2:0]        feed_t;

    // Operands are computed for the FEED index that becomes current after the next edge.
    always_comb begin
        load_ops = (state == StClear) || ((state == StFeed) && (feed_cnt != 3'd6));
        feed_t   = (state == StClear) ? 3'd0 : feed_cnt + 3'd1;
        for (int i = 0; i < 4; i++) begin
            west_d[i]  = '0;
            north_d[i] = '0;
            if (load_ops && (feed_t >= 3'(i)) && ((feed_t - 3'(i)) <= 3'd3)) begin
                west_d[i]  = a_mem[{2'(i), 2'(feed_t - 3'(i))}];
                north_d[i] = b_mem[{2'(feed_t - 3'(i)), 2'(i)}];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            feed_cnt  <= '0;
            drain_cnt <= '0;
            array_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
            end
        end else begin
            array_clr <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                west_q[i]  <= west_d[i];
                north_q[i] <= north_d[i];
            end
            if (state == StIdle) begin
                if (a_we) a_mem[a_addr] <= a_data;
                if (b_we) b_mem[b_addr] <= b_data;
            end
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StClear;
                        array_clr <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StClear: begin
                    state    <= StFeed;
                    feed_cnt <= '0;
                end
                StFeed: begin
                    if (feed_cnt == 3'd6) begin
                        state     <= StDrain;
                        feed_cnt  <= '0;
                        drain_cnt <= '0;
                    end else begin
                        feed_cnt <= feed_cnt + 3'd1;
                    end
                end
                StDrain: begin
                    if (drain_cnt == 4'(DRAIN - 1)) begin
                        state     <= StDone;
                        done      <= 1'b1;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign inp_west0  = west_q[0];
    assign inp_west4  = west_q[1];
    assign inp_west8  = west_q[2];
    assign inp_west12 = west_q[3];
    assign inp_north0 = north_q[0];
    assign inp_north1 = north_q[1];
    assign inp_north2 = north_q[2];
    assign inp_north3 = north_q[3];

`ifdef SYSTOLIC_SEQ_CTRL_WRERR_EN
    logic wr_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err_q <= 1'b0;
        end else if ((a_we || b_we) && busy) begin
            wr_err_q <= 1'b1;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

endmodule
